// File: rtl/clk_tap_pwm_pkg.sv
// rtl/clk_tap_pwm_pkg.sv - shared state encoding and tap index constants for clk_tap_pwm
package clk_tap_pwm_pkg;

  localparam int N_TAPS_DEF  = 4;
  localparam int SEL_W_DEF   = 2;
  localparam int PHASE_W_DEF = 4;

  localparam int TAP_DIV2  = 0;
  localparam int TAP_DIV4  = 1;
  localparam int TAP_DIV8  = 2;
  localparam int TAP_DIV16 = 3;

  // 2'd3 is unused and falls back to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/clk_tap_pwm_if.sv
// rtl/clk_tap_pwm_if.sv - control/status bundle between a driver and clk_tap_pwm
// master: drives en, div_taps, tap_sel, duty; observes tick, pwm_out, period_done, phase
// slave : the clk_tap_pwm block
interface clk_tap_pwm_if
  import clk_tap_pwm_pkg::*;
#(
  parameter int N_TAPS  = N_TAPS_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF
);

  logic               en;
  logic [N_TAPS-1:0]  div_taps;
  logic [SEL_W-1:0]   tap_sel;
  logic [PHASE_W:0]   duty;
  logic               tick;
  logic               pwm_out;
  logic               period_done;
  logic [PHASE_W-1:0] phase;

  modport master (
    output en, div_taps, tap_sel, duty,
    input  tick, pwm_out, period_done, phase
  );

  modport slave (
    input  en, div_taps, tap_sel, duty,
    output tick, pwm_out, period_done, phase
  );

endinterface

// File: rtl/clk_tap_pwm_tap_edge_detect.sv
// rtl/clk_tap_pwm_tap_edge_detect.sv - two-stage tap sampler with per-bit rising-edge vector
// clk, reset : master clock, synchronous active-high reset
// taps       : divided clocks treated as data
// rise       : per-bit rising edge, combinational from the sample stages
module clk_tap_pwm_tap_edge_detect #(
  parameter int N_TAPS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_TAPS-1:0] taps,
  output logic [N_TAPS-1:0] rise
);

  logic [N_TAPS-1:0] taps_s;
  logic [N_TAPS-1:0] taps_p;
  logic              warm;

  always_ff @(posedge clk) begin
    if (reset) begin
      taps_s <= '0;
      taps_p <= '0;
      warm   <= 1'b0;
    end else begin
      taps_s <= taps;
      taps_p <= taps_s;
      warm   <= 1'b1;
    end
  end

  // Every bit is tracked, so re-pointing the selector never sees a stale history
  assign rise = {N_TAPS{warm}} & taps_s & ~taps_p;

endmodule

// File: rtl/clk_tap_pwm.sv
// rtl/clk_tap_pwm.sv - tick, phase counter and PWM driven by one selected divider tap
// clk, reset : master clock, synchronous active-high reset
// bus        : en/div_taps/tap_sel/duty in, tick/pwm_out/period_done/phase out
module clk_tap_pwm
  import clk_tap_pwm_pkg::*;
#(
  parameter int N_TAPS  = N_TAPS_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  clk_tap_pwm_if.slave bus
);

  state_t             state;
  logic               tick_r;
  logic               pwm_r;
  logic               done_r;
  logic [PHASE_W-1:0] phase_r;

  logic [N_TAPS-1:0]  rise;
  logic [SEL_W-1:0]   sel_idx;
  logic               rise_sel;

  clk_tap_pwm_tap_edge_detect #(
    .N_TAPS (N_TAPS)
  ) u_tap_edge_detect (
    .clk   (clk),
    .reset (reset),
    .taps  (bus.div_taps),
    .rise  (rise)
  );

  // Out-of-range selections fall back to the div2 tap
  assign sel_idx  = (32'(bus.tap_sel) < N_TAPS) ? bus.tap_sel : SEL_W'(TAP_DIV2);
  assign rise_sel = rise[sel_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tick_r  <= 1'b0;
      pwm_r   <= 1'b0;
      done_r  <= 1'b0;
      phase_r <= '0;
    end else begin
      tick_r <= 1'b0;
      pwm_r  <= 1'b0;
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          phase_r <= '0;
          if (bus.en) state <= ARM;
        end
        ARM: begin
          phase_r <= '0;
          if (!bus.en) begin
            state <= IDLE;
          end else if (rise_sel) begin
            // First edge anchors the period; this tick keeps phase at 0
            state  <= RUN;
            tick_r <= 1'b1;
          end
        end
        RUN: begin
          if (!bus.en) begin
            state   <= IDLE;
            phase_r <= '0;
          end else begin
            tick_r <= rise_sel;
            // Compares the phase currently on the output, so pwm lags phase by one cycle
            pwm_r  <= ({1'b0, phase_r} < bus.duty);
            if (tick_r) begin
              phase_r <= phase_r + PHASE_W'(1);
              done_r  <= (phase_r == '1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          phase_r <= '0;
        end
      endcase
    end
  end

  assign bus.tick        = tick_r;
  assign bus.pwm_out     = pwm_r;
  assign bus.period_done = done_r;
  assign bus.phase       = phase_r;

endmodule

// File: tb/tb_clk_tap_pwm.sv
// tb/tb_clk_tap_pwm.sv - directed self-checking bench for clk_tap_pwm
module tb_clk_tap_pwm;
  import clk_tap_pwm_pkg::*;

  logic clk;
  logic reset;
  logic div_run;
  logic [4:0] dcnt;
  int checks;
  int errors;

  clk_tap_pwm_if #(.N_TAPS(4), .SEL_W(2), .PHASE_W(4)) bus ();

  clk_tap_pwm #(.N_TAPS(4), .SEL_W(2), .PHASE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; taps change just after the edge, outputs are sampled there too.
  // Divider model: div2 has a 4-clk period, div16 a 32-clk period.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      dcnt = dcnt + 5'd1;
      if (div_run) bus.div_taps = dcnt[4:1];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n, bad, ticks, pwm_hi, pd_cnt, pd_first, pd_second, pd_bad;
    int seen8, pwm_at8, pwm_after8, t_first, t_second;

    checks = 0;
    errors = 0;
    dcnt = 5'd0;
    div_run = 1'b0;
    reset = 1'b1;
    bus.en = 1'b0;
    bus.div_taps = 4'b1111;
    bus.tap_sel = 2'(TAP_DIV2);
    bus.duty = 5'd8;

    // Reset state with taps held high
    cyc(3);
    chk("rst_tick", 32'(bus.tick), 32'd0);
    chk("rst_pwm", 32'(bus.pwm_out), 32'd0);
    chk("rst_done", 32'(bus.period_done), 32'd0);
    chk("rst_phase", 32'(bus.phase), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));

    // Released, en=0: nothing moves for 20 cycles
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (bus.tick || bus.pwm_out || bus.period_done || bus.phase != 4'd0) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    // en=1 with no tap edges: parks in ARM
    bus.en = 1'b1;
    cyc(6);
    chk("arm_state", 32'(dut.state), 32'(ARM));
    chk("arm_pwm", 32'(bus.pwm_out), 32'd0);
    chk("arm_tick", 32'(bus.tick), 32'd0);

    // Real divider, div2 tap, duty 8: div2 rises at n=2, tick at n=4
    dcnt = 5'd0;
    div_run = 1'b1;
    bus.div_taps = 4'b0000;
    n = 0;
    while (!bus.tick && n < 20) begin
      cyc(1);
      n++;
    end
    chk("first_tick_lat", 32'(n), 32'd4);
    chk("first_tick_phase", 32'(bus.phase), 32'd0);
    chk("run_state", 32'(dut.state), 32'(RUN));

    ticks = 0; pwm_hi = 0; pd_cnt = 0; pd_first = -1; pd_second = -1; pd_bad = 0;
    seen8 = 0; pwm_at8 = -1; pwm_after8 = -1;
    for (int c = 1; c <= 128; c++) begin
      cyc(1);
      if (bus.tick) ticks++;
      if (bus.pwm_out) pwm_hi++;
      if (bus.period_done) begin
        pd_cnt++;
        if (bus.phase != 4'd0) pd_bad++;
        if (pd_first < 0) pd_first = c;
        else if (pd_second < 0) pd_second = c;
      end
      if (bus.phase == 4'd8 && seen8 == 0) begin
        seen8 = 1;
        pwm_at8 = int'(bus.pwm_out);
      end else if (seen8 == 1) begin
        seen8 = 2;
        pwm_after8 = int'(bus.pwm_out);
      end
    end
    chk("div2_ticks", 32'(ticks), 32'd32);
    chk("div2_pwm_high", 32'(pwm_hi), 32'd64);
    chk("div2_done_cnt", 32'(pd_cnt), 32'd2);
    chk("div2_done_first", 32'(pd_first), 32'd61);
    chk("div2_done_gap", 32'(pd_second - pd_first), 32'd64);
    chk("done_phase0", 32'(pd_bad), 32'd0);
    chk("pwm_lag_at8", 32'(pwm_at8), 32'd1);
    chk("pwm_lag_after8", 32'(pwm_after8), 32'd0);

    // div16 tap, duty 0: no pwm, ticks 32 clk apart
    bus.tap_sel = 2'(TAP_DIV16);
    bus.duty = 5'd0;
    ticks = 0; pwm_hi = 0; t_first = -1; t_second = -1;
    for (int c = 1; c <= 96; c++) begin
      cyc(1);
      if (bus.tick) begin
        ticks++;
        if (t_first < 0) t_first = c;
        else if (t_second < 0) t_second = c;
      end
      if (bus.pwm_out) pwm_hi++;
    end
    chk("div16_ticks", 32'(ticks), 32'd3);
    chk("div16_gap", 32'(t_second - t_first), 32'd32);
    chk("duty0_pwm", 32'(pwm_hi), 32'd0);

    // duty 16: pwm constantly high in RUN
    bus.duty = 5'd16;
    ticks = 0; pwm_hi = 0;
    for (int c = 1; c <= 64; c++) begin
      cyc(1);
      if (bus.tick) ticks++;
      if (bus.pwm_out) pwm_hi++;
    end
    chk("duty16_pwm", 32'(pwm_hi), 32'd64);
    chk("duty16_ticks", 32'(ticks), 32'd2);

    // Switch 0 -> 2 while div8 has been high: next div8 rise 14 clk later, tick at 16
    bus.tap_sel = 2'(TAP_DIV2);
    bus.duty = 5'd8;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (dcnt[3:0] != 4'd10 && n < 40);
    chk("sync_div8", 32'(dcnt[3:0]), 32'd10);
    bus.tap_sel = 2'(TAP_DIV8);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!bus.tick && n < 40);
    chk("switch_tick_lat", 32'(n), 32'd16);

    // Deassert en at phase 9
    n = 0;
    while (bus.phase != 4'd9 && n < 400) begin
      cyc(1);
      n++;
    end
    chk("reach_phase9", 32'(bus.phase), 32'd9);
    bus.en = 1'b0;
    cyc(1);
    chk("dis_phase", 32'(bus.phase), 32'd0);
    chk("dis_pwm", 32'(bus.pwm_out), 32'd0);
    chk("dis_tick", 32'(bus.tick), 32'd0);
    chk("dis_state", 32'(dut.state), 32'(IDLE));
    bus.en = 1'b1;
    cyc(1);
    chk("reen_state", 32'(dut.state), 32'(ARM));
    n = 0;
    while (!bus.tick && n < 40) begin
      cyc(1);
      n++;
    end
    chk("reen_tick_seen", 32'(bus.tick), 32'd1);
    chk("reen_tick_phase", 32'(bus.phase), 32'd0);
    chk("reen_tick_pwm", 32'(bus.pwm_out), 32'd0);
    chk("reen_run", 32'(dut.state), 32'(RUN));
    cyc(1);
    chk("reen_phase1", 32'(bus.phase), 32'd1);

    // Reset at phase 15 with the wrapping tick on the output
    bus.tap_sel = 2'(TAP_DIV2);
    n = 0;
    while (!(bus.phase == 4'd15 && bus.tick) && n < 400) begin
      cyc(1);
      n++;
    end
    chk("reach_wrap_tick", 32'(bus.tick && bus.phase == 4'd15), 32'd1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("mid_rst_done", 32'(bus.period_done), 32'd0);
    chk("mid_rst_tick", 32'(bus.tick), 32'd0);
    chk("mid_rst_pwm", 32'(bus.pwm_out), 32'd0);
    chk("mid_rst_phase", 32'(bus.phase), 32'd0);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
